sys_bus_interconnect: RTL and testbench

//  Parametrised 1-master/N-slave bus fabric between the LSU memory port and the system's

---
 rtl/sys_bus_interconnect.sv | 172 +++++++++++++++++
 tb/tb_sys_bus_interconnect.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_interconnect.sv
// sys_bus_interconnect: 1-master / N-slave memory-mapped bus fabric.
// The slave index comes from address field [SEL_MSB:SEL_LSB]. The request is
// latched and held on the slave side until that slave is ready or the access
// times out. The master then sees a registered one-cycle response.
// Optional feature macro: BUS_ERR_CAPTURE_EN (sticky first-error address capture).
module sys_bus_interconnect #(
    parameter int N_SLAVES = 8,
    parameter int SEL_MSB  = 31,
    parameter int SEL_LSB  = 24,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  m_req_i,
    input  logic                  m_we_i,
    input  logic [3:0]            m_be_i,
    input  logic [31:0]           m_addr_i,
    input  logic [31:0]           m_wd_i,
    output logic [31:0]           m_rd_o,
    output logic                  m_ready_o,
    output logic                  m_err_o,
    output logic [N_SLAVES-1:0]   s_req_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_wd_o,
    input  logic [32*N_SLAVES-1:0] s_rd_i,
    input  logic [N_SLAVES-1:0]   s_ready_i,
    output logic [31:0]           err_addr_o,
    output logic                  err_valid_o,
    input  logic                  err_clr_i
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rd;
    logic             r_err;

    logic [31:0]      w_sel_ext;
    logic             w_sel_ok;
    logic             w_sel_ready;
    logic             w_expire;
    logic [31:0]      w_addr_masked;

    assign w_sel_ext   = 32'(m_addr_i[SEL_MSB:SEL_LSB]);
    assign w_sel_ok    = (w_sel_ext < 32'(N_SLAVES));
    assign w_sel_ready = s_ready_i[r_sel];
    assign w_expire    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // Slaves see a device-relative address: the select field is stripped.
    always_comb begin
        w_addr_masked = m_addr_i;
        w_addr_masked[SEL_MSB:SEL_LSB] = '0;
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state decode and state-derived outputs (slave request, master response).
    always_comb begin
        w_state_nxt = r_state;
        s_req_o     = '0;
        m_ready_o   = 1'b0;
        m_rd_o      = '0;
        m_err_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_req_i) w_state_nxt = w_sel_ok ? ST_BUSY : ST_RESP;
            end
            ST_BUSY: begin
                s_req_o = N_SLAVES'(1) << r_sel;
                if (w_sel_ready || w_expire) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                m_ready_o   = 1'b1;
                m_rd_o      = r_rd;
                m_err_o     = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response capture; ready beats expiry.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            s_we_o   <= 1'b0;
            s_be_o   <= '0;
            s_addr_o <= '0;
            s_wd_o   <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_req_i) begin
                        s_we_o   <= m_we_i;
                        s_be_o   <= m_be_i;
                        s_addr_o <= w_addr_masked;
                        s_wd_o   <= m_wd_i;
                        r_cnt    <= '0;
                        if (w_sel_ok) begin
                            r_sel <= w_sel_ext[IDX_W-1:0];
                        end else begin
                            r_rd  <= '0;
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                    if (w_sel_ready) begin
                        r_rd  <= s_we_o ? 32'h0 : s_rd_i[32*int'(r_sel) +: 32];
                        r_err <= 1'b0;
                    end else if (w_expire) begin
                        r_rd  <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BUS_ERR_CAPTURE_EN
    logic [31:0] r_err_addr;
    logic        r_err_valid;
    logic        w_err_entry;

    // The master holds its payload until m_ready_o, so m_addr_i is still the
    // original full address when either error path enters RESP.
    assign w_err_entry = ((r_state == ST_IDLE) && m_req_i && !w_sel_ok) ||
                         ((r_state == ST_BUSY) && !w_sel_ready && w_expire);

    // Sticky first-error capture; a new capture beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_err_addr  <= '0;
            r_err_valid <= 1'b0;
        end else if (w_err_entry && !r_err_valid) begin
            r_err_addr  <= m_addr_i;
            r_err_valid <= 1'b1;
        end else if (err_clr_i) begin
            r_err_addr  <= '0;
            r_err_valid <= 1'b0;
        end
    end

    assign err_addr_o  = r_err_addr;
    assign err_valid_o = r_err_valid;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr_i;
    assign err_addr_o  = '0;
    assign err_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Directed bench for sys_bus_interconnect (N_SLAVES=8, SEL 31:24, TIMEOUT=16).
// Slave k returns 0xCAFE_000k and raises ready on a programmable BUSY cycle.
module tb_sys_bus_interconnect;

    localparam int N = 8;

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic          m_req_i, m_we_i;
    logic [3:0]    m_be_i;
    logic [31:0]   m_addr_i, m_wd_i;
    logic [31:0]   m_rd_o;
    logic          m_ready_o, m_err_o;
    logic [N-1:0]  s_req_o;
    logic          s_we_o;
    logic [3:0]    s_be_o;
    logic [31:0]   s_addr_o, s_wd_o;
    logic [32*N-1:0] s_rd_i;
    logic [N-1:0]  s_ready_i;
    logic [31:0]   err_addr_o;
    logic          err_valid_o;
    logic          err_clr_i;

    int            n_total = 0;
    int            n_bad   = 0;
    int            ready_cyc = 0;     // BUSY cycle (1-based) on which the slave is ready; 0 = never
    logic [N-1:0]  noise = '0;        // ready bits of slaves that are not selected
    int            busy_cnt = 0;

    logic [31:0]   exp_eaddr;
    logic          exp_evld;

    sys_bus_interconnect #(.N_SLAVES(N), .SEL_MSB(31), .SEL_LSB(24), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wd_i(m_wd_i),
        .m_rd_o(m_rd_o), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wd_o(s_wd_o),
        .s_rd_i(s_rd_i), .s_ready_i(s_ready_i),
        .err_addr_o(err_addr_o), .err_valid_o(err_valid_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Slave read data is fixed per slave.
    always_comb begin
        for (int k = 0; k < N; k++) s_rd_i[32*k +: 32] = 32'hCAFE_0000 | 32'(k);
    end

    // Count consecutive cycles with a slave request outstanding.
    always @(posedge clk_i) begin
        if (s_req_o != '0) busy_cnt <= busy_cnt + 1;
        else               busy_cnt <= 0;
    end

    always_comb begin
        s_ready_i = noise;
        if (ready_cyc != 0 && busy_cnt == ready_cyc - 1) s_ready_i = s_ready_i | s_req_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one transfer from IDLE and report latency, response and what the slaves saw.
    task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output logic [N-1:0] req_or, output int req_cyc,
                        output logic [N-1:0] req_resp);
        bit done = 0;
        lat = 0; rd = '0; err = 1'b0; req_or = '0; req_cyc = 0; req_resp = '0;
        m_req_i = 1'b1; m_we_i = we; m_be_i = be; m_addr_i = addr; m_wd_i = wd;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk_i); #1;
            if (s_req_o != '0) begin
                req_or  = req_or | s_req_o;
                req_cyc = req_cyc + 1;
            end
            if (m_ready_o) begin
                lat = c; rd = m_rd_o; err = m_err_o; req_resp = s_req_o;
                done = 1;
                break;
            end
        end
        if (!done) chk("response_wait", 32'(0), 32'(1));
        m_req_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    int           lat, rcyc;
    logic [31:0]  rd;
    logic         err;
    logic [N-1:0] ror, rresp;

    initial begin
        resetn_i = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = '0;
        m_addr_i = '0; m_wd_i = '0; err_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(m_ready_o), 32'h0);
        chk("rst_req",   32'(s_req_o),   32'h0);
        chk("rst_addr",  s_addr_o,       32'h0);
        chk("rst_rd",    m_rd_o,         32'h0);
        chk("rst_evld",  32'(err_valid_o), 32'h0);
        resetn_i = 1'b1;
        @(posedge clk_i); #1;

        // 1: read from slave 1, ready on 3rd BUSY cycle
        ready_cyc = 3;
        xfer(1'b0, 4'hF, 32'h0100_0010, 32'h0, lat, rd, err, ror, rcyc, rresp);
        chk("s1_lat", 32'(lat), 32'd4);
        chk("s1_rd", rd, 32'hCAFE_0001);
        chk("s1_err", 32'(err), 32'h0);
        chk("s1_req", 32'(ror), 32'h02);
        chk("s1_reqcyc", 32'(rcyc), 32'd3);
        chk("s1_addr", s_addr_o, 32'h0000_0010);
        chk("s1_we", 32'(s_we_o), 32'h0);

        // 2: write to slave 2, ready on first BUSY cycle
        ready_cyc = 1;
        xfer(1'b1, 4'b0011, 32'h0200_0004, 32'h1234_5678, lat, rd, err, ror, rcyc, rresp);
        chk("s2_lat", 32'(lat), 32'd2);
        chk("s2_rd", rd, 32'h0);
        chk("s2_err", 32'(err), 32'h0);
        chk("s2_req", 32'(ror), 32'h04);
        chk("s2_req_resp", 32'(rresp), 32'h0);
        chk("s2_we", 32'(s_we_o), 32'h1);
        chk("s2_be", 32'(s_be_o), 32'h3);
        chk("s2_wd", s_wd_o, 32'h1234_5678);
        chk("s2_addr", s_addr_o, 32'h0000_0004);

        // 3: decode error
        xfer(1'b0, 4'hF, 32'h0900_0000, 32'h0, lat, rd, err, ror, rcyc, rresp);
        chk("s3_lat", 32'(lat), 32'd1);
        chk("s3_err", 32'(err), 32'h1);
        chk("s3_rd", rd, 32'h0);
        chk("s3_req", 32'(ror), 32'h0);
`ifdef BUS_ERR_CAPTURE_EN
        exp_eaddr = 32'h0900_0000; exp_evld = 1'b1;
`else
        exp_eaddr = 32'h0; exp_evld = 1'b0;
`endif
        chk("s3_eaddr", err_addr_o, exp_eaddr);
        chk("s3_evld", 32'(err_valid_o), 32'(exp_evld));

        // 4a: slave 3 never ready, slave 0 ready noise must be ignored
        ready_cyc = 0; noise = 8'h01;
        xfer(1'b0, 4'hF, 32'h0300_0000, 32'h0, lat, rd, err, ror, rcyc, rresp);
        chk("s4a_lat", 32'(lat), 32'd17);
        chk("s4a_err", 32'(err), 32'h1);
        chk("s4a_rd", rd, 32'h0);
        chk("s4a_req", 32'(ror), 32'h08);
        chk("s4a_reqcyc", 32'(rcyc), 32'd16);
        chk("s4a_eaddr", err_addr_o, exp_eaddr);

        // 4b: ready on the expiry cycle wins
        ready_cyc = 16; noise = '0;
        xfer(1'b0, 4'hF, 32'h0300_0000, 32'h0, lat, rd, err, ror, rcyc, rresp);
        chk("s4b_lat", 32'(lat), 32'd17);
        chk("s4b_err", 32'(err), 32'h0);
        chk("s4b_rd", rd, 32'hCAFE_0003);

        // 5: reset on the 2nd BUSY cycle
        ready_cyc = 3;
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0100_0010;
        @(posedge clk_i); #1;
        chk("s5_busy_req", 32'(s_req_o), 32'h02);
        @(posedge clk_i); #1;
        resetn_i = 1'b0;
        @(posedge clk_i); #1;
        m_req_i = 1'b0;
        chk("s5_req", 32'(s_req_o), 32'h0);
        chk("s5_ready", 32'(m_ready_o), 32'h0);
        chk("s5_addr", s_addr_o, 32'h0);
        chk("s5_evld", 32'(err_valid_o), 32'h0);
        @(posedge clk_i); #1;
        resetn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("s5_no_ready", 32'(m_ready_o), 32'h0);
        end
        xfer(1'b0, 4'hF, 32'h0100_0010, 32'h0, lat, rd, err, ror, rcyc, rresp);
        chk("s5_lat", 32'(lat), 32'd4);
        chk("s5_rd", rd, 32'hCAFE_0001);

        // 6: first error sticks, later errors do not overwrite, clear zeroes
        xfer(1'b0, 4'hF, 32'h0900_0000, 32'h0, lat, rd, err, ror, rcyc, rresp);
        xfer(1'b0, 4'hF, 32'h0900_0000, 32'h0, lat, rd, err, ror, rcyc, rresp);
        xfer(1'b0, 4'hF, 32'h0A00_0000, 32'h0, lat, rd, err, ror, rcyc, rresp);
        chk("s6_err", 32'(err), 32'h1);
        chk("s6_eaddr", err_addr_o, exp_eaddr);
        chk("s6_evld", 32'(err_valid_o), 32'(exp_evld));
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        chk("s6_clr_eaddr", err_addr_o, 32'h0);
        chk("s6_clr_evld", 32'(err_valid_o), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
